// File: rtl/lsu_mem_initiator_if.sv
// Data-memory bus between the LSU initiator and memory.
// Access codes shared by the LSU and its neighbours.
package lsu_pkg;
  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;
endpackage

interface lsu_mem_initiator_if #(
    parameter int ADDR_W = 17
) ();
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;

    modport master (
        output mem_req, mem_we, mem_be,
        output mem_addr, mem_wdata,
        input  mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_req, mem_we, mem_be,
        input  mem_addr, mem_wdata,
        output mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// LSU initiator: one request in, one word access out,
// one formatted response back per accepted request.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 17,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [1:0]  fault,
    lsu_mem_initiator_if.master mem
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STORE, S_WAIT, S_RESP
    } state_t;

    state_t     state;
    logic [5:0] op;
    logic [1:0] off;
    logic [7:0] cnt;

    logic       ld_c, st_c, w_acc, h_acc;
    logic [1:0] acc_fault;
    logic [3:0] be;

    assign ld_c  = alucode inside {ALU_LB, ALU_LH, ALU_LW,
                                   ALU_LBU, ALU_LHU};
    assign st_c  = alucode inside {ALU_SB, ALU_SH, ALU_SW};
    assign w_acc = alucode inside {ALU_LW, ALU_SW};
    assign h_acc = alucode inside {ALU_LH, ALU_LHU, ALU_SH};

    always_comb begin
        be = 4'b0001 << addr[1:0];
        unique case (1'b1)
            w_acc:   be = 4'b1111;
            h_acc:   be = 4'b0011 << addr[1:0];
            default: be = 4'b0001 << addr[1:0];
        endcase
    end

    // Priority: type mismatch, out of range, then misalignment.
    always_comb begin
        acc_fault = 2'd0;
        if (!is_load && !is_store)
            acc_fault = 2'd0;
        else if ((is_load && is_store) ||
                 (is_load && !ld_c) ||
                 (is_store && !st_c))
            acc_fault = 2'd2;
        else if ((addr >> ADDR_W) != 32'd0)
            acc_fault = 2'd2;
        else if ((w_acc && addr[1:0] != 2'd0) ||
                 (h_acc && addr[1:0] == 2'd3))
            acc_fault = 2'd1;
    end

    function automatic logic [31:0] fmt(
        input logic [5:0]  c,
        input logic [1:0]  o,
        input logic [31:0] w
    );
        logic [31:0] s;
        s = w >> {o, 3'b000};
        unique case (c)
            ALU_LB:  fmt = {{24{s[7]}}, s[7:0]};
            ALU_LBU: fmt = {24'd0, s[7:0]};
            ALU_LH:  fmt = {{16{s[15]}}, s[15:0]};
            ALU_LHU: fmt = {16'd0, s[15:0]};
            default: fmt = w;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            req_ready     <= 1'b1;
            stall         <= 1'b0;
            resp_valid    <= 1'b0;
            resp_data     <= 32'd0;
            fault         <= 2'd0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= 4'd0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= 32'd0;
            op            <= 6'd0;
            off           <= 2'd0;
            cnt           <= 8'd0;
        end else begin
            unique case (state)
                S_IDLE: if (req_valid) begin
                    op            <= alucode;
                    off           <= addr[1:0];
                    req_ready     <= 1'b0;
                    stall         <= 1'b1;
                    mem.mem_addr  <= addr[ADDR_W-1:2];
                    mem.mem_be    <= be;
                    mem.mem_we    <= is_store;
                    mem.mem_wdata <= st_data << {addr[1:0], 3'b000};
                    if ((!is_load && !is_store) ||
                        acc_fault != 2'd0) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= 32'd0;
                        fault      <= acc_fault;
                    end else if (is_load) begin
                        state       <= S_LOAD;
                        mem.mem_req <= 1'b1;
                    end else begin
                        state       <= S_STORE;
                        mem.mem_req <= 1'b1;
                    end
                end
                S_LOAD: begin
                    mem.mem_req <= 1'b0;
                    cnt         <= 8'd0;
                    state       <= S_WAIT;
                end
                S_STORE: begin
                    mem.mem_req <= 1'b0;
                    state       <= S_RESP;
                    resp_valid  <= 1'b1;
                    resp_data   <= 32'd0;
                    fault       <= 2'd0;
                end
                S_WAIT: begin
                    if (mem.mem_rvalid) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= fmt(op, off, mem.mem_rdata);
                        fault      <= 2'd0;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= 32'd0;
                        fault      <= 2'd3;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    stall      <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a 1-cycle
// read memory model that can be muted for timeouts.
module tb_lsu_mem_initiator;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [5:0]  alucode = 6'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  fault;

    int n_cmp = 0;
    int n_err = 0;

    logic mem_on = 1'b1;
    logic kick = 1'b0;

    // Observations from the last run_req
    int          o_nreq, o_reqcyc, o_rcyc;
    logic        o_we, o_ready, o_stall1;
    logic [3:0]  o_be;
    logic [14:0] o_addr;
    logic [31:0] o_wdata, o_data;
    logic [1:0]  o_fault;

    lsu_mem_initiator_if #(.ADDR_W(17)) mem ();

    lsu_mem_initiator #(.ADDR_W(17), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .is_load(is_load), .is_store(is_store),
        .alucode(alucode), .addr(addr), .st_data(st_data),
        .stall(stall), .resp_valid(resp_valid),
        .resp_data(resp_data), .fault(fault),
        .mem(mem.master)
    );

    always #5 clk = ~clk;

    assign mem.mem_rdata = 32'h80FF7F01;
    always @(posedge clk)
        mem.mem_rvalid <= (mem_on && mem.mem_req && !mem.mem_we)
                          || kick;

    task automatic run_req(input logic ld, input logic st,
                           input logic [5:0] c,
                           input logic [31:0] a,
                           input logic [31:0] d);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        is_load = ld; is_store = st; alucode = c;
        addr = a; st_data = d; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        o_nreq = 0; o_reqcyc = 0; o_rcyc = 0;
        o_we = 0; o_be = 0; o_addr = 0; o_wdata = 0;
        o_data = 32'hX; o_fault = 2'bXX; o_ready = 1'bX;
        o_stall1 = stall;
        for (int k = 1; k <= 40; k++) begin
            if (mem.mem_req) begin
                o_nreq++;
                o_reqcyc = k;
                o_we = mem.mem_we; o_be = mem.mem_be;
                o_addr = mem.mem_addr; o_wdata = mem.mem_wdata;
            end
            if (resp_valid) begin
                o_rcyc = k; o_data = resp_data;
                o_fault = fault; o_ready = req_ready;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 7;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_ready got %b want 1", req_ready);
        end
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL rst_stall got %b want 0", stall);
        end
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_rv got %b want 0", resp_valid);
        end
        if (mem.mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rst_req got %b want 0", mem.mem_req);
        end
        if (fault !== 2'd0) begin
            n_err++;
            $display("FAIL rst_fault got %0d want 0", fault);
        end
        if (resp_data !== 32'd0) begin
            n_err++;
            $display("FAIL rst_data got %h want 0", resp_data);
        end
        if (mem.mem_be !== 4'd0) begin
            n_err++;
            $display("FAIL rst_be got %b want 0", mem.mem_be);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_store();
        logic [5:0]  c [3];
        logic [31:0] a [3], d [3], ew [3];
        logic [3:0]  eb [3];
        c  = '{ALU_SW, ALU_SB, ALU_SH};
        a  = '{32'h100, 32'h103, 32'h101};
        d  = '{32'hDEADBEEF, 32'h000000A5, 32'h00001234};
        eb = '{4'b1111, 4'b1000, 4'b0110};
        ew = '{32'hDEADBEEF, 32'hA5000000, 32'h00123400};
        for (int i = 0; i < 3; i++) begin
            run_req(1'b0, 1'b1, c[i], a[i], d[i]);
            n_cmp += 9;
            if (o_nreq !== 1 || o_reqcyc !== 1) begin
                n_err++;
                $display("FAIL st%0d_req n=%0d cyc=%0d want 1/1",
                         i, o_nreq, o_reqcyc);
            end
            if (o_we !== 1'b1) begin
                n_err++;
                $display("FAIL st%0d_we got %b want 1", i, o_we);
            end
            if (o_addr !== 15'h40) begin
                n_err++;
                $display("FAIL st%0d_addr got %h want 40", i, o_addr);
            end
            if (o_be !== eb[i]) begin
                n_err++;
                $display("FAIL st%0d_be got %b want %b",
                         i, o_be, eb[i]);
            end
            if (o_wdata !== ew[i]) begin
                n_err++;
                $display("FAIL st%0d_wdata got %h want %h",
                         i, o_wdata, ew[i]);
            end
            if (o_rcyc !== 2) begin
                n_err++;
                $display("FAIL st%0d_lat got %0d want 2", i, o_rcyc);
            end
            if (o_fault !== 2'd0) begin
                n_err++;
                $display("FAIL st%0d_fault got %0d want 0", i, o_fault);
            end
            if (o_ready !== 1'b0) begin
                n_err++;
                $display("FAIL st%0d_rdy got %b want 0", i, o_ready);
            end
            if (o_stall1 !== 1'b1) begin
                n_err++;
                $display("FAIL st%0d_stall got %b want 1", i, o_stall1);
            end
        end
    endtask

    task automatic test_load();
        logic [5:0]  c [5];
        logic [31:0] a [5], e [5];
        logic [3:0]  eb [5];
        c  = '{ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW};
        a  = '{32'h103, 32'h103, 32'h101, 32'h102, 32'h100};
        e  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFF7F,
               32'h000080FF, 32'h80FF7F01};
        eb = '{4'b1000, 4'b1000, 4'b0110, 4'b1100, 4'b1111};
        for (int i = 0; i < 5; i++) begin
            run_req(1'b1, 1'b0, c[i], a[i], 32'd0);
            n_cmp += 5;
            if (o_data !== e[i]) begin
                n_err++;
                $display("FAIL ld%0d_data got %h want %h",
                         i, o_data, e[i]);
            end
            if (o_rcyc !== 3) begin
                n_err++;
                $display("FAIL ld%0d_lat got %0d want 3", i, o_rcyc);
            end
            if (o_fault !== 2'd0) begin
                n_err++;
                $display("FAIL ld%0d_fault got %0d want 0", i, o_fault);
            end
            if (o_be !== eb[i] || o_we !== 1'b0) begin
                n_err++;
                $display("FAIL ld%0d_be got %b/%b want %b/0",
                         i, o_be, o_we, eb[i]);
            end
            if (o_nreq !== 1) begin
                n_err++;
                $display("FAIL ld%0d_nreq got %0d want 1", i, o_nreq);
            end
        end
    endtask

    task automatic test_fault();
        logic        ld [5], st [5];
        logic [5:0]  c [5];
        logic [31:0] a [5];
        logic [1:0]  ef [5];
        ld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        st = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        c  = '{ALU_LW, ALU_LH, ALU_LW, ALU_LW, ALU_LW};
        a  = '{32'h102, 32'h103, 32'h00020000, 32'h100, 32'h100};
        ef = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
        for (int i = 0; i < 5; i++) begin
            run_req(ld[i], st[i], c[i], a[i], 32'hFFFFFFFF);
            n_cmp += 4;
            if (o_fault !== ef[i]) begin
                n_err++;
                $display("FAIL ft%0d_fault got %0d want %0d",
                         i, o_fault, ef[i]);
            end
            if (o_nreq !== 0) begin
                n_err++;
                $display("FAIL ft%0d_nreq got %0d want 0", i, o_nreq);
            end
            if (o_rcyc !== 1) begin
                n_err++;
                $display("FAIL ft%0d_lat got %0d want 1", i, o_rcyc);
            end
            if (o_data !== 32'd0) begin
                n_err++;
                $display("FAIL ft%0d_data got %h want 0", i, o_data);
            end
        end
    endtask

    task automatic test_timeout();
        int seen;
        mem_on = 1'b0;
        run_req(1'b1, 1'b0, ALU_LW, 32'h100, 32'd0);
        n_cmp += 3;
        if (o_rcyc !== 17) begin
            n_err++;
            $display("FAIL to_lat got %0d want 17", o_rcyc);
        end
        if (o_fault !== 2'd3) begin
            n_err++;
            $display("FAIL to_fault got %0d want 3", o_fault);
        end
        if (o_data !== 32'd0) begin
            n_err++;
            $display("FAIL to_data got %h want 0", o_data);
        end
        @(negedge clk) kick = 1'b1;
        @(negedge clk) kick = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1 if (resp_valid) seen++;
        end
        n_cmp += 2;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL to_late got %0d pulses want 0", seen);
        end
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL to_ready got %b want 1", req_ready);
        end
        mem_on = 1'b1;
    endtask

    task automatic test_reset_mid();
        int seen;
        mem_on = 1'b0;
        @(negedge clk);
        is_load = 1'b1; is_store = 1'b0; alucode = ALU_LW;
        addr = 32'h100; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp += 3;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rm_ready got %b want 1", req_ready);
        end
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL rm_stall got %b want 0", stall);
        end
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rm_rv got %b want 0", resp_valid);
        end
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (resp_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL rm_silent got %0d pulses want 0", seen);
        end
        mem_on = 1'b1;
        run_req(1'b0, 1'b1, ALU_SW, 32'h100, 32'hCAFEF00D);
        n_cmp += 2;
        if (o_rcyc !== 2 || o_fault !== 2'd0) begin
            n_err++;
            $display("FAIL rm_sw lat=%0d fault=%0d want 2/0",
                     o_rcyc, o_fault);
        end
        if (o_wdata !== 32'hCAFEF00D || o_nreq !== 1) begin
            n_err++;
            $display("FAIL rm_sw_bus wdata=%h n=%0d want cafef00d/1",
                     o_wdata, o_nreq);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_fault();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
Initiator side of the CPU data-memory port: accepts one load/store request from the execute stage and issues a single word-addressed access with byte enables. For loads it waits for read data, then extracts and sign-/zero-extends the addressed byte or halfword. It returns one response per accepted request and stalls the pipeline while busy. Alucode values come from define.vh (ALU_LB/LH/LW/LBU/LHU/SB/SH/SW).

Parameters:
ADDR_W, 17, byte-address width of data memory; word address is ADDR_W-2 bits
TIMEOUT, 15, max cycles in S_WAIT without mem_rvalid before timeout fault (1..255)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present from execute stage
req_ready  out  1  high only in S_IDLE; request accepted when req_valid&req_ready
is_load  in  1  request is a load
is_store  in  1  request is a store
alucode  in  6  access type (ALU_* codes)
addr  in  32  byte address
st_data  in  32  store data, LSB-aligned
stall  out  1  high whenever state != S_IDLE
resp_valid  out  1  one-cycle pulse, one per accepted request
resp_data  out  32  formatted load data; 0 for stores and faults
fault  out  2  valid with resp_valid: 0 ok, 1 misaligned, 2 access, 3 timeout
mem_req  out  1  memory access strobe, exactly one cycle per access
mem_we  out  1  1 store, 0 load; valid with mem_req
mem_be  out  4  byte-lane enables; valid with mem_req
mem_addr  out  ADDR_W-2  word address = addr[ADDR_W-1:2]
mem_wdata  out  32  lane-positioned store data
mem_rdata  in  32  read word
mem_rvalid  in  1  read data valid

Behaviour:
- Reset: state S_IDLE; req_ready=1; stall, resp_valid, mem_req, mem_we=0; mem_be=0; fault=0; resp_data=0; mem_addr, mem_wdata=0; timeout counter=0. Reset mid-operation aborts silently: no response, mem_req drops next cycle.
- Accept (S_IDLE, req_valid): latch alucode, addr, st_data, is_load, is_store. Classify, priority top to bottom:
  - neither is_load nor is_store: S_RESP, fault=0, data 0.
  - both set, alucode not a load code with is_load, or not a store code with is_store: fault=2.
  - addr[31:ADDR_W] != 0: fault=2.
  - W access with addr[1:0]!=0, or H/HU with addr[1:0]==3: fault=1.
  - otherwise: load -> S_LOAD, store -> S_STORE.
- Faulted requests go to S_RESP and never assert mem_req.
- Lanes, off = addr[1:0]: B: be=4'b0001<<off; H: be=4'b0011<<off; W: be=4'b1111. mem_wdata = st_data<<(8*off). For loads the same mask is driven on mem_be.
- S_STORE: mem_req=1, mem_we=1 for one cycle, then S_RESP. Timing: accept at T, mem_req at T+1, resp_valid at T+2.
- S_LOAD: mem_req=1, mem_we=0 for one cycle, then S_WAIT with counter=0.
- S_WAIT: when mem_rvalid=1, capture mem_rdata, go to S_RESP. Else increment counter; when it reaches TIMEOUT, go to S_RESP with fault=3. With 1-cycle memory (rvalid at T+2), resp_valid is at T+3.
- Load formatting from captured word w:
  - LB: sign-extend w[8*off+7:8*off]; LBU: zero-extend the same byte.
  - LH: sign-extend w[8*off+15:8*off]; LHU: zero-extend the same halfword.
  - LW: w.
- S_RESP: resp_valid=1 for exactly one cycle with resp_data/fault, then S_IDLE. req_ready=0 here, so back-to-back requests are spaced by at least one idle-ready cycle.
- No response backpressure; the consumer must take resp_valid when it pulses.
- mem_rvalid outside S_WAIT is ignored.
- resp_data and fault hold their values between pulses. Only resp_valid qualifies them.

Test Plan:
- SW addr=0x100, st_data=0xDEADBEEF -> T+1: mem_req=1, we=1, mem_addr=0x40, be=1111, wdata=0xDEADBEEF. T+2: resp_valid, fault=0.
- SB addr=0x103, st_data=0x000000A5 -> be=1000, wdata=0xA5000000. SH addr=0x101, st_data=0x1234 -> be=0110, wdata=0x00123400.
- Memory returns 0x80FF7F01 with 1-cycle latency:
  - LB off 3 -> 0xFFFFFF80; LBU off 3 -> 0x00000080
  - LH off 1 -> 0xFFFFFF7F; LHU off 2 -> 0x000080FF
  - LW -> 0x80FF7F01
  - resp_valid at T+3 in each case.
- LW addr=0x102, LH addr=0x103 -> fault=1, no mem_req. addr=0x00020000 -> fault=2. is_load=is_store=1 -> fault=2.
- LW with mem_rvalid never asserted -> resp_valid after TIMEOUT=15 S_WAIT cycles, fault=3, resp_data=0. A late mem_rvalid afterwards is ignored.
- rst asserted during S_WAIT -> next cycle S_IDLE, req_ready=1, no resp_valid. A subsequent SW completes normally.
